// File: rtl/win_gen_pkg.sv
// Shared geometry for the sliding-window generator and the MAC array
// that consumes its windows. Frame size is set here once so both blocks
// agree on it.
package win_gen_pkg;

  localparam int IMG_W_DEF     = 28;
  localparam int IMG_H_DEF     = 28;
  localparam int DATA_W_DEF    = 8;
  localparam int COL_W_DEF     = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF     = $clog2(IMG_H_DEF);
  localparam int WIN_PER_FRAME = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

  // Number of fully interior 3x3 windows in a w x h frame (stride 1, no pad).
  function automatic int win_count(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

// File: rtl/win_gen_3x3_row_delay.sv
// row_delay: enable-gated delay line, DEPTH enables deep.
//   clk, rst_n : clock, async active-low reset (pointer only)
//   en         : advance the line by one pixel
//   din        : pixel entering the line
//   dout       : pixel that entered DEPTH enables ago (combinational read)
// Built as a circular RAM with a single pointer. The slot under the
// pointer is read before it is overwritten, so dout is valid in the same
// cycle as the din it pairs with. RAM contents have no reset.
module row_delay
  import win_gen_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= '0;
    else if (en) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

endmodule

// File: rtl/win_gen_3x3.sv
// win_gen_3x3: 3x3 sliding-window generator for the MAC array.
//   clk, rst_n        : clock, async active-low reset
//   clear             : synchronous frame abort (beats a same-cycle in_valid)
//   in_valid/in_pixel : raster-order pixel stream, gaps allowed
//   out_valid         : one-cycle pulse, win* hold a new interior window
//   win00..win22      : window, winRC = row R col C, win22 = newest pixel
//   out_row/out_col   : coordinates of win22 for the current window
//   frame_done        : pulses with the last window of the frame
// Two row delays provide rows r-1 and r-2 alongside the live pixel; each
// feeds a 3-tap column shift register. The shift registers are the window
// outputs, so a window is visible one clock after its completing pixel.
module win_gen_3x3
  import win_gen_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int COL_W = $clog2(IMG_W),
  localparam int ROW_W = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  output logic [DATA_W-1:0] win00,
  output logic [DATA_W-1:0] win01,
  output logic [DATA_W-1:0] win02,
  output logic [DATA_W-1:0] win10,
  output logic [DATA_W-1:0] win11,
  output logic [DATA_W-1:0] win12,
  output logic [DATA_W-1:0] win20,
  output logic [DATA_W-1:0] win21,
  output logic [DATA_W-1:0] win22,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              frame_done
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  // A dropped pixel (clear) must not move the line buffers or window regs.
  logic en;
  assign en = in_valid & ~clear;

  logic [DATA_W-1:0] lb1_q;  // row r-1, same column
  logic [DATA_W-1:0] lb2_q;  // row r-2, same column

  row_delay #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .din  (in_pixel),
    .dout (lb1_q)
  );

  row_delay #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb2 (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .din  (lb1_q),
    .dout (lb2_q)
  );

  // win_q[r][c]: r = 0 oldest row, c = 0 oldest column.
  logic [2:0][2:0][DATA_W-1:0] win_q;
  logic [2:0][DATA_W-1:0]      tap;

  assign tap[0] = lb2_q;
  assign tap[1] = lb1_q;
  assign tap[2] = in_pixel;

  // Columns 0 and 1 would straddle the previous row's tail; rows 0 and 1
  // may hold the previous frame. Neither position emits.
  logic emit, last;
  assign emit = en && (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
  assign last = en && (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

  // Raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Column shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (en) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
        win_q[r][2] <= tap[r];
      end
    end
  end

  // Emit flags and coordinates; coordinates hold between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid  <= emit;
      frame_done <= last;
      if (emit) begin
        out_row <= row_cnt;
        out_col <= col_cnt;
      end
    end
  end

  assign win00 = win_q[0][0];
  assign win01 = win_q[0][1];
  assign win02 = win_q[0][2];
  assign win10 = win_q[1][0];
  assign win11 = win_q[1][1];
  assign win12 = win_q[1][2];
  assign win20 = win_q[2][0];
  assign win21 = win_q[2][1];
  assign win22 = win_q[2][2];

endmodule
